// File: rtl/rotary_position_acc_pkg.sv
// Shared definitions for the rotary position accumulator: direction
// encodings, range-mode selectors, accelerator FSM states and a small
// clamp helper used when elaborating constants.
package rotary_position_acc_pkg;

   // Step direction as carried on i_cnt_cw / o_dir
   localparam logic DIR_CW  = 1'b1;
   localparam logic DIR_CCW = 1'b0;

   // Range behaviour at the MIN/MAX bounds
   localparam int WRAP_SATURATE = 0;
   localparam int WRAP_MODULO   = 1;

   // Accelerator FSM: IDLE means no recent step, TRACK means a step
   // happened recently enough that the next one may be accelerated
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_TRACK = 1'b1
   } acc_state_t;

   // Clamp an integer into [lo, hi]; used for parameter-derived constants
   function automatic int clamp_int(input int v, input int lo, input int hi);
      if (v < lo) begin
         return lo;
      end else if (v > hi) begin
         return hi;
      end
      return v;
   endfunction

endpackage : rotary_position_acc_pkg

// File: rtl/rotary_position_acc_step_timer.sv
// Interval timer for the accelerator. Counts clock cycles since the last
// accepted step, saturating at WINDOW so it never rolls over during long
// idle periods. o_fast is high while the count is still below WINDOW,
// i.e. a step taken now would follow the previous one closely enough to
// be accelerated. A count equal to WINDOW also tells the FSM the window
// has expired.
module rotary_step_timer #(
   parameter int WINDOW = 64
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   output logic o_fast
);

   localparam int CW = $clog2(WINDOW + 1);
   localparam logic [CW-1:0] WIN_C = CW'(WINDOW);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   logic [CW-1:0] count_q;

   // Cycle counter: restarts at zero on every accepted step, holds at WINDOW
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
      end else if (i_clear) begin
         count_q <= '0;
      end else if (count_q != WIN_C) begin
         count_q <= count_q + ONE_C;
      end
   end

   assign o_fast = (count_q < WIN_C);

endmodule : rotary_step_timer

// File: rtl/rotary_position_acc.sv
// Rotary position accumulator. Consumes the quadrature decoder's one-cycle
// step pulse and direction, keeps a bounded position (saturating or
// wrapping), enlarges steps when same-direction steps arrive in quick
// succession, and publishes changes to a host.
//
// Host handshake: o_valid rises on the edge where oa_value changes and
// stays high until the host pulses i_ack. An ack clears o_valid at the next
// edge unless that same edge also changes the value, in which case o_valid
// stays high so the new change is not lost. Several changes made while
// o_valid is high coalesce into one pending notification; an ack while
// o_valid is low has no effect.
//
// All outputs are registered and reflect an i_cnt/i_load sampled at the
// same rising edge. o_state exposes the accelerator FSM for observation.
module rotary_position_acc
   import rotary_position_acc_pkg::*;
#(
   parameter int VALUE_WIDTH  = 8,
   parameter int VALUE_MIN    = 0,
   parameter int VALUE_MAX    = 255,
   parameter int RESET_VALUE  = 0,
   parameter int WRAP         = WRAP_SATURATE,
   parameter int ACCEL_WINDOW = 64,
   parameter int ACCEL_STEP   = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_cnt,
   input  logic                   i_cnt_cw,
   input  logic                   i_load,
   input  logic [VALUE_WIDTH-1:0] ia_load_value,
   input  logic                   i_ack,
   output logic [VALUE_WIDTH-1:0] oa_value,
   output logic                   o_valid,
   output logic                   o_dir,
   output logic                   o_at_min,
   output logic                   o_at_max,
   output acc_state_t             o_state
);

   // Arithmetic is done signed, two bits wider than the value, so that
   // overshoot past MAX and undershoot below MIN are both representable.
   localparam int SW = VALUE_WIDTH + 2;
   typedef logic signed [SW-1:0] sval_t;

   localparam sval_t MIN_S   = sval_t'(VALUE_MIN);
   localparam sval_t MAX_S   = sval_t'(VALUE_MAX);
   localparam sval_t RANGE_S = sval_t'(VALUE_MAX - VALUE_MIN + 1);
   localparam sval_t FAST_S  = sval_t'(ACCEL_STEP);
   localparam sval_t SLOW_S  = sval_t'(1);

   localparam logic [VALUE_WIDTH-1:0] MIN_V = VALUE_WIDTH'(VALUE_MIN);
   localparam logic [VALUE_WIDTH-1:0] MAX_V = VALUE_WIDTH'(VALUE_MAX);
   localparam logic [VALUE_WIDTH-1:0] RST_V =
      VALUE_WIDTH'(clamp_int(RESET_VALUE, VALUE_MIN, VALUE_MAX));

   // Registered state
   acc_state_t               state_q;
   logic [VALUE_WIDTH-1:0]   value_q;
   logic                     valid_q;
   logic                     dir_q;
   logic                     at_min_q;
   logic                     at_max_q;

   // Next-state values
   acc_state_t               state_d;
   logic [VALUE_WIDTH-1:0]   value_d;
   logic                     valid_d;
   logic                     dir_d;
   logic                     changed;

   // Datapath intermediates
   logic                     fast;
   logic                     timer_clear;
   sval_t                    cur_s;
   sval_t                    step_mag;
   sval_t                    sum_s;
   sval_t                    step_res;
   sval_t                    load_s;
   sval_t                    load_res;
   logic [VALUE_WIDTH-1:0]   step_value;
   logic [VALUE_WIDTH-1:0]   load_value;
   logic                     unused_hi;

   rotary_step_timer #(
      .WINDOW (ACCEL_WINDOW)
   ) u_step_timer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (timer_clear),
      .o_fast  (fast)
   );

   // Candidate value for a step: size from the accelerator, then clamp or wrap
   always_comb begin
      cur_s    = $signed({2'b00, value_q});
      step_mag = SLOW_S;
      sum_s    = cur_s;
      step_res = cur_s;

      // Only a same-direction step inside the window is accelerated; the
      // first step after idle and any reversal move by one detent.
      if ((state_q == ST_TRACK) && fast && (i_cnt_cw == dir_q)) begin
         step_mag = FAST_S;
      end

      if (i_cnt_cw == DIR_CW) begin
         sum_s = cur_s + step_mag;
      end else begin
         sum_s = cur_s - step_mag;
      end

      // A single correction by the range width is enough as long as the
      // accelerated step is no larger than the range itself.
      if (WRAP == WRAP_MODULO) begin
         if (sum_s > MAX_S) begin
            step_res = sum_s - RANGE_S;
         end else if (sum_s < MIN_S) begin
            step_res = sum_s + RANGE_S;
         end else begin
            step_res = sum_s;
         end
      end else begin
         if (sum_s > MAX_S) begin
            step_res = MAX_S;
         end else if (sum_s < MIN_S) begin
            step_res = MIN_S;
         end else begin
            step_res = sum_s;
         end
      end

      step_value = step_res[VALUE_WIDTH-1:0];
   end

   // Candidate value for a load: the host value clamped into range
   always_comb begin
      load_s   = $signed({2'b00, ia_load_value});
      load_res = load_s;
      if (load_s > MAX_S) begin
         load_res = MAX_S;
      end else if (load_s < MIN_S) begin
         load_res = MIN_S;
      end
      load_value = load_res[VALUE_WIDTH-1:0];
   end

   // Results are always inside [MIN,MAX], so the guard bits carry nothing
   assign unused_hi = ^{step_res[SW-1:VALUE_WIDTH], load_res[SW-1:VALUE_WIDTH]};

   // Next-state logic: load beats step, then FSM window expiry and handshake
   always_comb begin
      state_d     = state_q;
      value_d     = value_q;
      dir_d       = dir_q;
      timer_clear = 1'b0;

      if (i_load) begin
         // A step arriving with a load is dropped; direction is untouched
         value_d     = load_value;
         state_d     = ST_IDLE;
         timer_clear = 1'b1;
      end else if (i_cnt) begin
         // Direction tracks every step, even one fully absorbed by a bound
         value_d     = step_value;
         dir_d       = i_cnt_cw;
         state_d     = ST_TRACK;
         timer_clear = 1'b1;
      end else if ((state_q == ST_TRACK) && !fast) begin
         state_d = ST_IDLE;
      end

      changed = (value_d != value_q);

      if (changed) begin
         valid_d = 1'b1;
      end else if (i_ack) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State register; reset discards any pending change
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         value_q  <= RST_V;
         valid_q  <= 1'b0;
         dir_q    <= DIR_CW;
         at_min_q <= (RST_V == MIN_V);
         at_max_q <= (RST_V == MAX_V);
      end else begin
         state_q  <= state_d;
         value_q  <= value_d;
         valid_q  <= valid_d;
         dir_q    <= dir_d;
         at_min_q <= (value_d == MIN_V);
         at_max_q <= (value_d == MAX_V);
      end
   end

   assign oa_value = value_q;
   assign o_valid  = valid_q;
   assign o_dir    = dir_q;
   assign o_at_min = at_min_q;
   assign o_at_max = at_max_q;
   assign o_state  = state_q;

endmodule : rotary_position_acc

// File: tb/tb_rotary_position_acc.sv
// Directed bench for rotary_position_acc. Two instances share the same
// stimulus: one saturating, one wrapping, both with range [0,20], reset
// value 10, window 8 and accelerated step 4. Inputs change on the falling
// edge and outputs are checked on the falling edge after the active edge.
module tb_rotary_position_acc;
   import rotary_position_acc_pkg::*;

   localparam int VW = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          cnt;
   logic          cnt_cw;
   logic          load;
   logic [VW-1:0] load_value;
   logic          ack;

   logic [VW-1:0] s_value, w_value;
   logic          s_valid, w_valid;
   logic          s_dir, w_dir;
   logic          s_at_min, w_at_min;
   logic          s_at_max, w_at_max;
   acc_state_t    s_state, w_state;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard of expected positions for the saturating instance
   logic [VW-1:0] exp_q[$];

   rotary_position_acc #(
      .VALUE_WIDTH(VW), .VALUE_MIN(0), .VALUE_MAX(20), .RESET_VALUE(10),
      .WRAP(WRAP_SATURATE), .ACCEL_WINDOW(8), .ACCEL_STEP(4)
   ) dut_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_cnt(cnt), .i_cnt_cw(cnt_cw),
      .i_load(load), .ia_load_value(load_value), .i_ack(ack),
      .oa_value(s_value), .o_valid(s_valid), .o_dir(s_dir),
      .o_at_min(s_at_min), .o_at_max(s_at_max), .o_state(s_state)
   );

   rotary_position_acc #(
      .VALUE_WIDTH(VW), .VALUE_MIN(0), .VALUE_MAX(20), .RESET_VALUE(10),
      .WRAP(WRAP_MODULO), .ACCEL_WINDOW(8), .ACCEL_STEP(4)
   ) dut_wrap (
      .i_clk(clk), .i_rst_n(rst_n), .i_cnt(cnt), .i_cnt_cw(cnt_cw),
      .i_load(load), .ia_load_value(load_value), .i_ack(ack),
      .oa_value(w_value), .o_valid(w_valid), .o_dir(w_dir),
      .o_at_min(w_at_min), .o_at_max(w_at_max), .o_state(w_state)
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_pos(input string tag);
      logic [VW-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(0), 32'(1));
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'(s_value), 32'(e));
      end
   endtask

   // ---------------- drivers ----------------
   // One-cycle drive of all inputs, sampled at the rising edge in between
   task automatic drive(input logic c, input logic cw, input logic ld,
                        input logic [VW-1:0] lv, input logic ak);
      @(negedge clk);
      cnt = c; cnt_cw = cw; load = ld; load_value = lv; ack = ak;
      @(negedge clk);
      cnt = 1'b0; cnt_cw = 1'b0; load = 1'b0; load_value = '0; ack = 1'b0;
   endtask

   task automatic step(input logic cw);
      drive(1'b1, cw, 1'b0, '0, 1'b0);
   endtask

   task automatic load_val(input logic [VW-1:0] v);
      drive(1'b0, 1'b0, 1'b1, v, 1'b0);
   endtask

   task automatic do_ack();
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      cnt = 1'b0; cnt_cw = 1'b0; load = 1'b0; load_value = '0; ack = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check("rst_value",  32'(s_value),  32'(10));
      check("rst_valid",  32'(s_valid),  32'(0));
      check("rst_dir",    32'(s_dir),    32'(1));
      check("rst_at_min", 32'(s_at_min), 32'(0));
      check("rst_at_max", 32'(s_at_max), 32'(0));
      check("rst_state",  32'(s_state),  32'(ST_IDLE));
      check("rst_wvalue", 32'(w_value),  32'(10));

      // Three slow cw detents, 12 cycles apart: 10 -> 13
      step(1'b1); idle(11);
      step(1'b1); idle(11);
      step(1'b1);
      check("t1_value", 32'(s_value), 32'(13));
      check("t1_dir",   32'(s_dir),   32'(1));
      check("t1_valid", 32'(s_valid), 32'(1));
      do_ack();
      check("t1_ack",   32'(s_valid), 32'(0));
      idle(12);
      check("t1_idle",  32'(s_state), 32'(ST_IDLE));

      // Four cw detents 4 cycles apart from 10: +1,+4,+4,+4 -> clamp 20
      load_val(8'd10);
      check("t2_load", 32'(s_value), 32'(10));
      do_ack();
      exp_q.push_back(8'd11); exp_q.push_back(8'd15);
      exp_q.push_back(8'd19); exp_q.push_back(8'd20);
      step(1'b1); check_pos("t2_s1"); idle(3);
      step(1'b1); check_pos("t2_s2"); idle(3);
      step(1'b1); check_pos("t2_s3"); idle(3);
      step(1'b1); check_pos("t2_s4");
      check("t2_at_max", 32'(s_at_max), 32'(1));
      check("t2_valid",  32'(s_valid),  32'(1));
      do_ack();
      check("t2_ack", 32'(s_valid), 32'(0));
      step(1'b1);
      check("t2_sat_value", 32'(s_value), 32'(20));
      check("t2_sat_valid", 32'(s_valid), 32'(0));

      // Fast cw then reversal inside the window, then a back-to-back ccw
      load_val(8'd10);
      do_ack();
      step(1'b1); idle(2);
      step(1'b1);
      check("t4_fast", 32'(s_value), 32'(15));
      idle(2);
      step(1'b0);
      check("t4_rev_value", 32'(s_value), 32'(14));
      check("t4_rev_dir",   32'(s_dir),   32'(0));
      step(1'b0);
      check("t4_b2b_value", 32'(s_value), 32'(10));

      // Load of 200 with a same-cycle cw step: clamp to 20, step dropped
      drive(1'b1, 1'b1, 1'b1, 8'd200, 1'b0);
      check("t5_value",  32'(s_value),  32'(20));
      check("t5_dir",    32'(s_dir),    32'(0));
      check("t5_state",  32'(s_state),  32'(ST_IDLE));
      check("t5_at_max", 32'(s_at_max), 32'(1));
      check("t5_valid",  32'(s_valid),  32'(1));
      do_ack();
      check("t5_ack", 32'(s_valid), 32'(0));
      // Ack together with a change keeps the notification
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
      check("t5_ackchg_value", 32'(s_value), 32'(19));
      check("t5_ackchg_valid", 32'(s_valid), 32'(1));
      do_ack();
      do_ack();
      check("t5_ack_idle", 32'(s_valid), 32'(0));
      // Loading the current value is not a change
      load_val(8'd19);
      check("t5_same_load", 32'(s_valid), 32'(0));
      load_val(8'd0);
      check("t5_at_min", 32'(s_at_min), 32'(1));
      do_ack();
      step(1'b0);
      check("t5_min_value", 32'(s_value), 32'(0));
      check("t5_min_valid", 32'(s_valid), 32'(0));
      // A step absorbed by the bound still records its direction
      load_val(8'd20);
      do_ack();
      step(1'b1);
      check("t5_max_dir",   32'(s_dir),   32'(1));
      check("t5_max_valid", 32'(s_valid), 32'(0));

      // Wrapping instance: 19 +1 -> 20, fast +4 -> 3; 0 -1 -> 20
      load_val(8'd19);
      step(1'b1);
      check("t3_w20", 32'(w_value), 32'(20));
      idle(3);
      step(1'b1);
      check("t3_wrap_up", 32'(w_value), 32'(3));
      load_val(8'd0);
      step(1'b0);
      check("t3_wrap_dn",  32'(w_value),  32'(20));
      check("t3_w_at_max", 32'(w_at_max), 32'(1));
      check("t3_w_dir",    32'(w_dir),    32'(0));

      // Asynchronous reset while a change is pending
      load_val(8'd5);
      check("t6_pending", 32'(s_valid), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("t6_value",  32'(s_value), 32'(10));
      check("t6_valid",  32'(s_valid), 32'(0));
      check("t6_dir",    32'(s_dir),   32'(1));
      check("t6_state",  32'(s_state), 32'(ST_IDLE));
      check("t6_wvalue", 32'(w_value), 32'(10));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      check("t6_post_valid", 32'(s_valid), 32'(0));
      check("t6_post_value", 32'(s_value), 32'(10));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_rotary_position_acc
